// File: rtl/chain_memory_controller.sv
// rtl/chain_memory_controller.sv - command-driven chain memory sequencer for the mining datapath
module chain_memory_controller #(
  parameter int DATA_W = 48,
  parameter int HASH_W = 8,
  parameter int DEPTH = 16,
  parameter int ACCESS_WAIT = 7,
  parameter int MINE_TIMEOUT = 255,
  parameter logic [HASH_W-1:0] GENESIS_HASH = '0,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [DATA_W-1:0] init_data,
  input  logic [DATA_W-1:0] datapath_out,
  input  logic [HASH_W-1:0] mining_hash,
  input  logic              done_mining,
  output logic [AW-1:0]     mem_addr,
  output logic              mem_sel,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              load_registers,
  output logic              load_previous_hash,
  output logic              use_genesis,
  output logic              enable_mining,
  output logic              rsp_valid,
  output logic [1:0]        rsp_status,
  output logic [AW:0]       chain_len
);

  localparam int CNT_MAX = (ACCESS_WAIT > MINE_TIMEOUT) ? ACCESS_WAIT : MINE_TIMEOUT;
  localparam int CW = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] LAST_ACCESS = CW'(ACCESS_WAIT - 1);
  localparam logic [CW-1:0] LAST_MINE = CW'(MINE_TIMEOUT - 1);
  localparam logic [AW:0] FULL_LEN = (AW + 1)'(DEPTH);
  localparam logic [AW-1:0] LAST_SLOT = AW'(DEPTH - 1);

  localparam logic [1:0] OP_INIT = 2'b00;
  localparam logic [1:0] OP_MINE = 2'b01;
  localparam logic [1:0] OP_REWIND = 2'b10;

  localparam logic [1:0] ST_OK = 2'b00;
  localparam logic [1:0] ST_FULL = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;
  localparam logic [1:0] ST_BADOP = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE, S_INIT_WR, S_LOAD, S_FETCH, S_MINE, S_WR_HASH, S_WR_DATA, S_RESP
  } state_t;

  state_t state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [AW-1:0] idx, idx_d;
  logic [AW:0] len_d;
  logic [1:0] status_d;
  logic restart;
  logic last;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state      <= S_IDLE;
      cnt        <= '0;
      idx        <= '0;
      chain_len  <= '0;
      rsp_status <= ST_OK;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      idx        <= idx_d;
      chain_len  <= len_d;
      rsp_status <= status_d;
    end
  end

  always_comb begin
    state_d  = state;
    idx_d    = idx;
    len_d    = chain_len;
    status_d = rsp_status;
    restart  = 1'b0;
    last     = (cnt == LAST_ACCESS);
    case (state)
      S_IDLE: begin
        if (cmd_valid) begin
          case (cmd_op)
            OP_INIT: begin
              state_d = S_INIT_WR;
              idx_d   = '0;
            end
            OP_MINE: begin
              if (chain_len == FULL_LEN) begin
                state_d  = S_RESP;
                status_d = ST_FULL;
              end else begin
                state_d = S_LOAD;
              end
            end
            OP_REWIND: begin
              state_d  = S_RESP;
              status_d = ST_OK;
              len_d    = '0;
            end
            default: begin
              state_d  = S_RESP;
              status_d = ST_BADOP;
            end
          endcase
        end
      end
      S_INIT_WR: begin
        if (last) begin
          if (idx == LAST_SLOT) begin
            state_d  = S_RESP;
            status_d = ST_OK;
            len_d    = '0;
          end else begin
            // next slot: same state, but the hold time starts over
            idx_d   = idx + 1'b1;
            restart = 1'b1;
          end
        end
      end
      S_LOAD:  if (last) state_d = (chain_len != '0) ? S_FETCH : S_MINE;
      S_FETCH: if (last) state_d = S_MINE;
      S_MINE: begin
        if (done_mining) begin
          state_d = S_WR_HASH;
        end else if (MINE_TIMEOUT != 0 && cnt == LAST_MINE) begin
          state_d  = S_RESP;
          status_d = ST_TIMEOUT;
        end
      end
      S_WR_HASH: if (last) state_d = S_WR_DATA;
      S_WR_DATA: begin
        if (last) begin
          state_d  = S_RESP;
          status_d = ST_OK;
          if (chain_len != FULL_LEN) len_d = chain_len + 1'b1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    cnt_d = (state_d != state || restart) ? '0 : cnt + 1'b1;
  end

  // Outputs are decoded from the next state/counter and registered, so each
  // strobe lines up with the state it belongs to without any input-to-output path.
  logic              cmd_ready_d, mem_sel_d, mem_we_d, load_registers_d;
  logic              load_previous_hash_d, use_genesis_d, enable_mining_d, rsp_valid_d;
  logic [AW-1:0]     mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_d;
  logic              fin_d;

  always_comb begin
    cmd_ready_d          = (state_d == S_IDLE);
    mem_sel_d            = 1'b0;
    mem_we_d             = 1'b0;
    mem_addr_d           = '0;
    mem_wdata_d          = '0;
    load_registers_d     = 1'b0;
    load_previous_hash_d = 1'b0;
    use_genesis_d        = 1'b0;
    enable_mining_d      = 1'b0;
    rsp_valid_d          = 1'b0;
    fin_d                = (cnt_d == LAST_ACCESS);
    case (state_d)
      S_INIT_WR: begin
        mem_we_d    = 1'b1;
        mem_addr_d  = idx_d;
        mem_wdata_d = init_data;
      end
      S_LOAD: begin
        mem_addr_d       = len_d[AW-1:0];
        load_registers_d = fin_d;
        if (fin_d && len_d == '0) begin
          load_previous_hash_d = 1'b1;
          use_genesis_d        = 1'b1;
        end
      end
      S_FETCH: begin
        mem_sel_d            = 1'b1;
        mem_addr_d           = len_d[AW-1:0] - 1'b1;
        load_previous_hash_d = fin_d;
      end
      S_MINE: enable_mining_d = 1'b1;
      S_WR_HASH: begin
        mem_we_d    = 1'b1;
        mem_sel_d   = 1'b1;
        mem_addr_d  = len_d[AW-1:0];
        mem_wdata_d = DATA_W'(mining_hash);
      end
      S_WR_DATA: begin
        mem_we_d    = 1'b1;
        mem_addr_d  = len_d[AW-1:0];
        mem_wdata_d = datapath_out;
      end
      S_RESP:  rsp_valid_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      cmd_ready          <= 1'b1;
      mem_sel            <= 1'b0;
      mem_we             <= 1'b0;
      mem_addr           <= '0;
      mem_wdata          <= '0;
      load_registers     <= 1'b0;
      load_previous_hash <= 1'b0;
      use_genesis        <= 1'b0;
      enable_mining      <= 1'b0;
      rsp_valid          <= 1'b0;
    end else begin
      cmd_ready          <= cmd_ready_d;
      mem_sel            <= mem_sel_d;
      mem_we             <= mem_we_d;
      mem_addr           <= mem_addr_d;
      mem_wdata          <= mem_wdata_d;
      load_registers     <= load_registers_d;
      load_previous_hash <= load_previous_hash_d;
      use_genesis        <= use_genesis_d;
      enable_mining      <= enable_mining_d;
      rsp_valid          <= rsp_valid_d;
    end
  end

endmodule

// File: tb/tb_chain_memory_controller.sv
// tb/tb_chain_memory_controller.sv - randomized directed bench with a slot-level reference model
module tb_chain_memory_controller;
  localparam int DATA_W = 48;
  localparam int HASH_W = 8;
  localparam int DEPTH = 4;
  localparam int AW = 2;
  localparam int W = 3;
  localparam int TO = 10;

  logic clock = 1'b0;
  logic resetn, cmd_valid, cmd_ready, done_mining;
  logic [1:0] cmd_op, rsp_status;
  logic [DATA_W-1:0] init_data, datapath_out, mem_wdata;
  logic [HASH_W-1:0] mining_hash;
  logic [AW-1:0] mem_addr;
  logic mem_sel, mem_we, load_registers, load_previous_hash, use_genesis, enable_mining, rsp_valid;
  logic [AW:0] chain_len;

  chain_memory_controller #(
    .DATA_W(DATA_W), .HASH_W(HASH_W), .DEPTH(DEPTH), .ACCESS_WAIT(W),
    .MINE_TIMEOUT(TO), .GENESIS_HASH(8'h00)
  ) dut (
    .clock(clock), .resetn(resetn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .init_data(init_data), .datapath_out(datapath_out),
    .mining_hash(mining_hash), .done_mining(done_mining), .mem_addr(mem_addr),
    .mem_sel(mem_sel), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .load_registers(load_registers), .load_previous_hash(load_previous_hash),
    .use_genesis(use_genesis), .enable_mining(enable_mining), .rsp_valid(rsp_valid),
    .rsp_status(rsp_status), .chain_len(chain_len)
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;

  // reference model: slot contents and chain length
  int m_cl;
  logic [DATA_W-1:0] m_data[DEPTH], m_hash[DEPTH];
  logic [DATA_W-1:0] o_data[DEPTH], o_hash[DEPTH];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
    chk({tag, "_strobes"}, 64'({mem_we, mem_sel, load_registers, load_previous_hash,
                                use_genesis, enable_mining, rsp_valid}), 64'd0);
    chk({tag, "_addr"}, 64'(mem_addr), 64'd0);
    chk({tag, "_wdata"}, 64'(mem_wdata), 64'd0);
  endtask

  task automatic randomize_data();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    init_data = r[DATA_W-1:0];
    r = {$urandom(), $urandom()};
    datapath_out = r[DATA_W-1:0];
    mining_hash = HASH_W'($urandom());
  endtask

  task automatic check_memories(input string tag);
    for (int i = 0; i < DEPTH; i++) begin
      chk($sformatf("%s_data%0d", tag, i), 64'(o_data[i]), 64'(m_data[i]));
      chk($sformatf("%s_hash%0d", tag, i), 64'(o_hash[i]), 64'(m_hash[i]));
    end
  endtask

  // Issue one command and watch it to completion; m = MINE cycle on which done_mining is seen (0 = never)
  task automatic run_cmd(input logic [1:0] op, input int m, output int lat, output int we_n,
                         output int en_n, output int lp_n, output int gen_n, output int lr_n);
    bit fin;
    lat = 0; we_n = 0; en_n = 0; lp_n = 0; gen_n = 0; lr_n = 0; fin = 0;
    @(negedge clock);
    chk("ready_before_cmd", 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b1;
    cmd_op = op;
    @(posedge clock);
    #1 cmd_valid = 1'b0;
    while (!fin && lat < 300) begin
      @(negedge clock);
      lat++;
      if (mem_we) begin
        we_n++;
        if (mem_sel) o_hash[mem_addr] = mem_wdata;
        else o_data[mem_addr] = mem_wdata;
        if (op == 2'b00) begin
          chk("init_addr", 64'(mem_addr), 64'((lat - 1) / W));
          chk("init_sel", 64'(mem_sel), 64'd0);
        end else begin
          chk("mine_wr_addr", 64'(mem_addr), 64'(m_cl));
        end
      end
      if (load_previous_hash && !use_genesis) begin
        chk("fetch_sel", 64'(mem_sel), 64'd1);
        chk("fetch_addr", 64'(mem_addr), 64'(m_cl - 1));
      end
      if (enable_mining) en_n++;
      if (load_previous_hash) lp_n++;
      if (use_genesis) gen_n++;
      if (load_registers) lr_n++;
      done_mining = (m > 0 && enable_mining && en_n == m);
      if (rsp_valid) fin = 1;
      else if (cmd_ready) chk("ready_while_busy", 64'(cmd_ready), 64'd0);
    end
    done_mining = 1'b0;
    if (!fin) chk("rsp_never_arrived", 64'd0, 64'd1);
  endtask

  task automatic init_step();
    int lat, we_n, en_n, lp_n, gen_n, lr_n;
    randomize_data();
    run_cmd(2'b00, 0, lat, we_n, en_n, lp_n, gen_n, lr_n);
    for (int i = 0; i < DEPTH; i++) m_data[i] = init_data;
    m_cl = 0;
    chk("init_latency", 64'(lat), 64'(DEPTH * W + 1));
    chk("init_we_cycles", 64'(we_n), 64'(DEPTH * W));
    chk("init_status", 64'(rsp_status), 64'd0);
    chk("init_chain_len", 64'(chain_len), 64'd0);
    check_memories("init");
  endtask

  task automatic mine_step(input int m);
    int lat, we_n, en_n, lp_n, gen_n, lr_n;
    int e_lat, e_we, e_en, e_lp, e_gen, e_lr, e_st, prior;
    randomize_data();
    prior = m_cl;
    if (m_cl == DEPTH) begin
      e_lat = 1; e_we = 0; e_en = 0; e_lp = 0; e_gen = 0; e_lr = 0; e_st = 1;
    end else begin
      e_lr = 1; e_lp = 1; e_gen = (m_cl == 0) ? 1 : 0;
      if (m == 0 || m > TO) begin
        e_lat = (m_cl > 0 ? 2 * W : W) + TO + 1;
        e_we = 0; e_en = TO; e_st = 2;
      end else begin
        e_lat = (m_cl > 0 ? 4 * W : 3 * W) + m + 1;
        e_we = 2 * W; e_en = m; e_st = 0;
      end
    end
    run_cmd(2'b01, m, lat, we_n, en_n, lp_n, gen_n, lr_n);
    if (e_st == 0) begin
      m_hash[m_cl] = DATA_W'(mining_hash);
      m_data[m_cl] = datapath_out;
      m_cl++;
    end
    chk($sformatf("mine%0d_latency", prior), 64'(lat), 64'(e_lat));
    chk($sformatf("mine%0d_we_cycles", prior), 64'(we_n), 64'(e_we));
    chk($sformatf("mine%0d_en_cycles", prior), 64'(en_n), 64'(e_en));
    chk($sformatf("mine%0d_prev_hash", prior), 64'(lp_n), 64'(e_lp));
    chk($sformatf("mine%0d_genesis", prior), 64'(gen_n), 64'(e_gen));
    chk($sformatf("mine%0d_load_regs", prior), 64'(lr_n), 64'(e_lr));
    chk($sformatf("mine%0d_status", prior), 64'(rsp_status), 64'(e_st));
    chk($sformatf("mine%0d_chain_len", prior), 64'(chain_len), 64'(m_cl));
    check_memories("mine");
  endtask

  task automatic simple_step(input logic [1:0] op, input int e_st);
    int lat, we_n, en_n, lp_n, gen_n, lr_n;
    run_cmd(op, 0, lat, we_n, en_n, lp_n, gen_n, lr_n);
    if (op == 2'b10) m_cl = 0;
    chk($sformatf("op%0d_latency", op), 64'(lat), 64'd1);
    chk($sformatf("op%0d_status", op), 64'(rsp_status), 64'(e_st));
    chk($sformatf("op%0d_we_cycles", op), 64'(we_n), 64'd0);
    chk($sformatf("op%0d_chain_len", op), 64'(chain_len), 64'(m_cl));
  endtask

  initial begin
    int steps, seen;
    resetn = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; done_mining = 1'b0;
    init_data = '0; datapath_out = '0; mining_hash = '0;
    m_cl = 0;
    for (int i = 0; i < DEPTH; i++) begin
      m_data[i] = '0; m_hash[i] = '0; o_data[i] = '0; o_hash[i] = '0;
    end
    repeat (2) @(negedge clock);
    chk_idle_outputs("reset");
    chk("reset_chain_len", 64'(chain_len), 64'd0);
    chk("reset_status", 64'(rsp_status), 64'd0);
    resetn = 1'b1;

    init_step();
    mine_step(6);
    mine_step(int'($urandom_range(8, 1)));
    mine_step(0);
    mine_step(TO);
    mine_step(int'($urandom_range(8, 1)));
    mine_step(int'($urandom_range(8, 1)));
    mine_step(int'($urandom_range(8, 1)));
    simple_step(2'b10, 0);
    simple_step(2'b11, 3);

    // abort a mine during its hash write-back
    randomize_data();
    @(negedge clock);
    cmd_valid = 1'b1; cmd_op = 2'b01;
    @(posedge clock);
    #1 cmd_valid = 1'b0;
    steps = 0; seen = 0;
    while (!(mem_we && mem_sel) && steps < 100) begin
      @(negedge clock);
      steps++;
      if (enable_mining) seen++;
      done_mining = (enable_mining && seen == 3);
    end
    done_mining = 1'b0;
    chk("abort_reached_wr_hash", 64'(mem_we && mem_sel), 64'd1);
    o_hash[mem_addr] = mem_wdata;
    m_hash[0] = DATA_W'(mining_hash);
    resetn = 1'b0;
    @(negedge clock);
    chk_idle_outputs("abort");
    chk("abort_chain_len", 64'(chain_len), 64'd0);
    resetn = 1'b1;
    seen = 0;
    repeat (6) begin
      @(negedge clock);
      if (rsp_valid || mem_we) seen++;
    end
    chk("abort_no_activity", 64'(seen), 64'd0);
    m_cl = 0;
    check_memories("abort");

    init_step();
    mine_step(int'($urandom_range(12, 1)));
    mine_step(int'($urandom_range(8, 1)));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
